// File: rtl/sample_iter_ctrl_pkg.sv
// Shared types and helpers for the sample iteration controller.
// Coordinates are signed fixed-point with RADIX fraction bits; a sample is a
// packed {y,x} pair and a triangle is VERTS x AXIS coordinates.
package sample_iter_ctrl_pkg;

    localparam int SIGFIG = 24;
    localparam int RADIX  = 10;
    localparam int VERTS  = 3;
    localparam int AXIS   = 3;

    // One full pixel in fixed-point units.
    localparam logic [SIGFIG-1:0] ONE_PX = {{(SIGFIG-1){1'b0}}, 1'b1} << RADIX;

    typedef struct packed {
        logic signed [SIGFIG-1:0] y;
        logic signed [SIGFIG-1:0] x;
    } sample_t;

    typedef logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ITER = 1'b1
    } iter_state_t;

    // Subsample pitch: one pixel divided by 2^ss_w_lg2.
    function automatic logic [SIGFIG-1:0] ss_step(input logic [1:0] ss_w_lg2);
        return ONE_PX >> ss_w_lg2;
    endfunction

    // Sign-extend a coordinate by one bit so coordinate+step cannot wrap.
    function automatic logic signed [SIGFIG:0] widen(input logic signed [SIGFIG-1:0] v);
        return $signed({v[SIGFIG-1], v});
    endfunction

    function automatic logic signed [SIGFIG:0] add_step(input logic signed [SIGFIG-1:0] v,
                                                        input logic [SIGFIG-1:0] step);
        return widen(v) + $signed({1'b0, step});
    endfunction

    // A sample is the last of its box when neither axis can advance further.
    function automatic logic sample_is_last(input sample_t s, input sample_t ur,
                                            input logic [SIGFIG-1:0] step);
        return (add_step(s.x, step) > widen(ur.x)) && (add_step(s.y, step) > widen(ur.y));
    endfunction

    function automatic logic box_empty(input sample_t ll, input sample_t ur);
        return ($signed(ur.x) < $signed(ll.x)) || ($signed(ur.y) < $signed(ll.y));
    endfunction

endpackage

// File: rtl/sample_iter_ctrl_if.sv
// Handshake bundle between the bounding-box stage, the iteration controller
// and the sample-test datapath.
//   upstream  : in_valid, in_ready, tri_i, box_ll_i, box_ur_i, ss_w_lg2_i
//   downstream: out_valid, out_ready, tri_o, sample_o, last_o
// slave is the controller side, master is the surrounding environment.
interface sample_iter_ctrl_if;
    import sample_iter_ctrl_pkg::*;

    logic       in_valid;
    logic       in_ready;
    tri_t       tri_i;
    sample_t    box_ll_i;
    sample_t    box_ur_i;
    logic [1:0] ss_w_lg2_i;
    logic       out_valid;
    logic       out_ready;
    tri_t       tri_o;
    sample_t    sample_o;
    logic       last_o;

    modport master (
        output in_valid, tri_i, box_ll_i, box_ur_i, ss_w_lg2_i, out_ready,
        input  in_ready, out_valid, tri_o, sample_o, last_o
    );

    modport slave (
        input  in_valid, tri_i, box_ll_i, box_ur_i, ss_w_lg2_i, out_ready,
        output in_ready, out_valid, tri_o, sample_o, last_o
    );

endinterface

// File: rtl/sample_iter_ctrl_stepper.sv
// sample_stepper: combinational raster-order advance, x-major.
// Ports:
//   cur      - sample currently presented
//   ll_x     - left edge of the box (x wraps back here)
//   ur       - inclusive upper-right corner
//   step     - subsample pitch
//   nxt      - sample that follows cur
//   nxt_last - nxt is the final sample of the box
module sample_stepper
    import sample_iter_ctrl_pkg::*;
(
    input  sample_t                  cur,
    input  logic signed [SIGFIG-1:0] ll_x,
    input  sample_t                  ur,
    input  logic [SIGFIG-1:0]        step,
    output sample_t                  nxt,
    output logic                     nxt_last
);

    logic signed [SIGFIG:0] x_sum_s;
    logic signed [SIGFIG:0] y_sum_s;

    // Advance x while it stays inside the box, otherwise wrap to the next row.
    always_comb begin
        x_sum_s  = add_step(cur.x, step);
        y_sum_s  = add_step(cur.y, step);
        nxt      = cur;
        if (x_sum_s <= widen(ur.x)) begin
            nxt.x = x_sum_s[SIGFIG-1:0];
        end else begin
            nxt.x = ll_x;
            nxt.y = y_sum_s[SIGFIG-1:0];
        end
        nxt_last = sample_is_last(nxt, ur, step);
    end

endmodule

// File: rtl/sample_iter_ctrl.sv
// sample_iter_ctrl: accepts one triangle with its bounding box and walks every
// subsample position in the box, presenting each to the sample-test stage.
// Ports:
//   clk, rst - clock, asynchronous active-high reset
//   bus      - slave side of sample_iter_ctrl_if (upstream accept, downstream
//              sample stream with last marker)
// All outputs are registered. last_o is precomputed for the sample being
// loaded so it is valid in the same cycle as that sample.
module sample_iter_ctrl
    import sample_iter_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    sample_iter_ctrl_if.slave bus
);

    iter_state_t              state_r;
    tri_t                     tri_r;
    logic signed [SIGFIG-1:0] ll_x_r;
    sample_t                  ur_r;
    logic [SIGFIG-1:0]        step_r;
    sample_t                  sample_r;
    logic                     last_r;
    logic                     in_ready_r;
    logic                     out_valid_r;

    sample_t                  nxt_s;
    logic                     nxt_last_s;
    logic [SIGFIG-1:0]        in_step_s;
    logic                     first_last_s;
    logic                     in_empty_s;

    assign in_step_s    = ss_step(bus.ss_w_lg2_i);
    assign first_last_s = sample_is_last(bus.box_ll_i, bus.box_ur_i, in_step_s);
    assign in_empty_s   = box_empty(bus.box_ll_i, bus.box_ur_i);

    sample_stepper u_stepper (
        .cur      (sample_r),
        .ll_x     (ll_x_r),
        .ur       (ur_r),
        .step     (step_r),
        .nxt      (nxt_s),
        .nxt_last (nxt_last_s)
    );

    // Iteration FSM with all outputs held in registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            tri_r       <= '0;
            ll_x_r      <= '0;
            ur_r        <= '0;
            step_r      <= '0;
            sample_r    <= '0;
            last_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid && in_ready_r) begin
                        tri_r  <= bus.tri_i;
                        ll_x_r <= bus.box_ll_i.x;
                        ur_r   <= bus.box_ur_i;
                        step_r <= in_step_s;
                        // An empty box is consumed without emitting anything.
                        if (!in_empty_s) begin
                            state_r     <= ITER;
                            sample_r    <= bus.box_ll_i;
                            last_r      <= first_last_s;
                            in_ready_r  <= 1'b0;
                            out_valid_r <= 1'b1;
                        end
                    end
                end
                ITER: begin
                    if (bus.out_ready) begin
                        if (last_r) begin
                            // in_ready rises only after the final handshake.
                            state_r     <= IDLE;
                            last_r      <= 1'b0;
                            in_ready_r  <= 1'b1;
                            out_valid_r <= 1'b0;
                        end else begin
                            sample_r <= nxt_s;
                            last_r   <= nxt_last_s;
                        end
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    last_r      <= 1'b0;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.tri_o     = tri_r;
    assign bus.sample_o  = sample_r;
    assign bus.last_o    = last_r;

endmodule

// File: tb/tb_sample_iter_ctrl.sv
// Directed testbench for sample_iter_ctrl. Outputs are sampled on the falling
// edge; the expected sample order is produced by nested row/column loops.
module tb_sample_iter_ctrl;
    import sample_iter_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    sample_iter_ctrl_if bus ();

    sample_iter_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic sample_t mk(input int x, input int y);
        sample_t s;
        s.x = x[SIGFIG-1:0];
        s.y = y[SIGFIG-1:0];
        return s;
    endfunction

    // Present one triangle, then follow its sample stream.
    // rdy_pat: out_ready per cycle (bit cyc%4); rst_at: sample index at which
    // reset is pulsed, or -1 for none.
    task automatic run_tri(input string name, input int llx, input int lly,
                           input int urx, input int ury, input logic [1:0] lg2,
                           input int exp_n, input logic [3:0] rdy_pat, input int rst_at);
        sample_t exp_q[$];
        tri_t    t;
        int      step;
        int      idx;
        int      cyc;
        int      tmp;
        bit      done;

        step = 1024 >> lg2;
        for (int y = lly; y <= ury; y += step)
            for (int x = llx; x <= urx; x += step)
                exp_q.push_back(mk(x, y));
        for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++) begin
                tmp = llx + 7 * ury + 16 * v + a;
                t[v][a] = tmp[SIGFIG-1:0];
            end

        @(negedge clk);
        bus.in_valid   = 1'b1;
        bus.tri_i      = t;
        bus.box_ll_i   = mk(llx, lly);
        bus.box_ur_i   = mk(urx, ury);
        bus.ss_w_lg2_i = lg2;
        bus.out_ready  = rdy_pat[0];
        check({name, ".in_ready_idle"}, {255'd0, bus.in_ready}, 256'd1);

        @(negedge clk);
        bus.in_valid   = 1'b0;
        bus.ss_w_lg2_i = ~lg2;
        bus.tri_i      = ~t;

        if (exp_n == 0) begin
            check({name, ".empty_valid"}, {255'd0, bus.out_valid}, 256'd0);
            check({name, ".empty_in_ready"}, {255'd0, bus.in_ready}, 256'd1);
            @(negedge clk);
            check({name, ".empty_valid2"}, {255'd0, bus.out_valid}, 256'd0);
            return;
        end

        check({name, ".first_valid"}, {255'd0, bus.out_valid}, 256'd1);
        idx  = 0;
        cyc  = 0;
        done = 1'b0;
        while (!done) begin
            bus.out_ready = rdy_pat[cyc % 4];
            if (rst_at >= 0 && idx == rst_at) begin
                rst = 1'b1;
                #1;
                check({name, ".rst_valid"}, {255'd0, bus.out_valid}, 256'd0);
                check({name, ".rst_in_ready"}, {255'd0, bus.in_ready}, 256'd1);
                check({name, ".rst_sample"}, {208'd0, bus.sample_o}, 256'd0);
                @(negedge clk);
                rst  = 1'b0;
                done = 1'b1;
            end else begin
                check({name, ".valid"}, {255'd0, bus.out_valid}, 256'd1);
                check({name, ".sample"}, {208'd0, bus.sample_o}, {208'd0, exp_q[idx]});
                check({name, ".last"}, {255'd0, bus.last_o},
                      {255'd0, (idx == exp_q.size() - 1)});
                check({name, ".tri"}, {40'd0, bus.tri_o}, {40'd0, t});
                check({name, ".in_ready_busy"}, {255'd0, bus.in_ready}, 256'd0);
                if (bus.out_ready) idx++;
                cyc++;
                if (idx >= exp_q.size() || cyc >= 300) done = 1'b1;
                @(negedge clk);
            end
        end

        if (rst_at < 0) begin
            check({name, ".count"}, idx, exp_n);
            check({name, ".done_valid"}, {255'd0, bus.out_valid}, 256'd0);
            check({name, ".done_in_ready"}, {255'd0, bus.in_ready}, 256'd1);
            check({name, ".done_last"}, {255'd0, bus.last_o}, 256'd0);
        end
    endtask

    initial begin
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b0;
        bus.tri_i      = '0;
        bus.box_ll_i   = '0;
        bus.box_ur_i   = '0;
        bus.ss_w_lg2_i = 2'd0;
        #12;
        check("reset.in_ready", {255'd0, bus.in_ready}, 256'd1);
        check("reset.out_valid", {255'd0, bus.out_valid}, 256'd0);
        check("reset.last", {255'd0, bus.last_o}, 256'd0);
        check("reset.sample", {208'd0, bus.sample_o}, 256'd0);
        check("reset.tri", {40'd0, bus.tri_o}, 256'd0);
        @(negedge clk);
        rst = 1'b0;

        // x-major walk, full pixel pitch: 3 x 2 = 6 samples
        run_tri("box6", 0, 0, 2048, 1024, 2'd0, 6, 4'b1111, -1);
        // half-pixel pitch over the same box: 5 x 3 = 15 samples
        run_tri("box15", 0, 0, 2048, 1024, 2'd1, 15, 4'b1111, -1);
        // single-sample box
        run_tri("single", 5120, 3072, 5120, 3072, 2'd0, 1, 4'b1111, -1);
        // empty box (ur_x < ll_x)
        run_tri("empty", 1024, 0, 0, 0, 2'd0, 0, 4'b1111, -1);
        // downstream stalls with out_ready pattern 1,0,0,1
        run_tri("stall", 0, 0, 1024, 1024, 2'd0, 4, 4'b1001, -1);
        // negative coordinates, half-pixel pitch: 3 x 2 = 6 samples
        run_tri("neg", -1024, -512, 0, 0, 2'd1, 6, 4'b1111, -1);
        // reset while the third sample is presented
        run_tri("rst_mid", 0, 0, 2048, 1024, 2'd0, 6, 4'b1111, 2);
        // next triangle starts at its own lower-left corner
        run_tri("after_rst", 1024, 2048, 2048, 2048, 2'd0, 2, 4'b1111, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
